// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for the memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_I  = 2'd1,
        S_BUSY_D  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of D grants taken while I waits
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count,
    output logic       at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && count != LIM) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-cache and D-cache block transfers onto one memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    state_t state, state_nx;
    owner_t owner;
    logic   i_req, d_req;
    logic   grant_d, grant_i, done;
    logic   at_limit;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign owner = (state == S_BUSY_D) ? OWN_D : OWN_I;
    assign busy  = (state != S_IDLE);

    // D normally wins; once I has lost STARVE_LIMIT times in a row it is forced through.
    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_req && !(i_req && at_limit)) begin
                    grant_d  = 1'b1;
                    state_nx = S_BUSY_D;
                end else if (i_req) begin
                    grant_i  = 1'b1;
                    state_nx = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ready) begin
                    done     = 1'b1;
                    state_nx = S_RELEASE;
                end
            end
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state   <= state_nx;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (grant_d) begin
                mem_write <= d_write;
                mem_read  <= d_read & ~d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
                mem_addr  <= i_addr;
            end
            if (done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (owner == OWN_I) begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    if (mem_read) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (grant_d & i_req),
        .clr     (grant_i),
        .count   (),
        .at_limit(at_limit)
    );

endmodule
